// File: rtl/cpu_pkg.sv
// Shared decode/execute constants for the mini CPU: immediate modes and
// occupancy encodings for the two-entry skid buffer.
// No logic; imported by imm_ext_core and imm_ext_pipe.
package cpu_pkg;

    // Immediate extension modes carried alongside every immediate.
    localparam logic [1:0] IMM_MODE_ZERO = 2'b00;
    localparam logic [1:0] IMM_MODE_SIGN = 2'b01;
    localparam logic [1:0] IMM_MODE_LUI  = 2'b10;
    localparam logic [1:0] IMM_MODE_RSVD = 2'b11;

    // Skid buffer occupancy; 2'b11 is unused and recovers to OCC_EMPTY.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_TWO   = 2'b10
    } occ_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Purpose : combinational immediate extender (zero / sign / load-upper / reserved).
// Latency : 0 cycles, purely combinational.
// Backpressure: none; the caller registers the result.
// Ports: imm[IN_W] + mode[2] in; data[OUT_W] + err out.
// Macro IMM_EXT_LUI_EN: when undefined, load-upper is treated as reserved and
// no shifting logic exists.
module imm_ext_core
    import cpu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data,
    output logic             err
);

    always_comb begin
        // Zero-extended value is the fallback for every mode, including reserved.
        data            = '0;
        err             = 1'b0;
        data[IN_W-1:0]  = imm;
        case (mode)
            IMM_MODE_ZERO: begin
            end
            IMM_MODE_SIGN: begin
                // Loop runs zero times when IN_W == OUT_W.
                for (int i = IN_W; i < OUT_W; i++) begin
                    data[i] = imm[IN_W-1];
                end
            end
`ifdef IMM_EXT_LUI_EN
            IMM_MODE_LUI: begin
                // With IN_W == OUT_W this degenerates to the zero-extend result.
                data                   = '0;
                data[OUT_W-1 -: IN_W]  = imm;
            end
`endif
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Purpose : registered immediate extender with a 2-entry valid/ready skid buffer.
// Latency : 1 cycle (accept at edge N, out_valid in cycle N+1); 1 result/cycle.
// Backpressure: in_ready drops only when both entries are full; decoded from state only.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_imm/in_mode;
//        out_valid/out_ready/out_data/out_err.
// Macro IMM_EXT_LUI_EN enables load-upper mode (otherwise mode 10 is reserved).
module imm_ext_pipe
    import cpu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    occ_state_t       state;
    logic [OUT_W-1:0] head_data;
    logic             head_err;
    logic [OUT_W-1:0] skid_data;
    logic             skid_err;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic             accept;
    logic             pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data),
        .err  (ext_err)
    );

    // Handshake flags come straight from the state register, so in_ready never
    // sees out_ready combinationally. The unused encoding drives both low.
    assign in_ready  = (state == OCC_EMPTY) || (state == OCC_ONE);
    assign out_valid = (state == OCC_ONE)   || (state == OCC_TWO);
    assign out_data  = head_data;
    assign out_err   = head_err;

    assign accept = in_valid  && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= OCC_EMPTY;
            head_data <= '0;
            head_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_data <= ext_data;
                        head_err  <= ext_err;
                        state     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        head_data <= ext_data;
                        head_err  <= ext_err;
                    end else if (accept) begin
                        skid_data <= ext_data;
                        skid_err  <= ext_err;
                        state     <= OCC_TWO;
                    end else if (pop) begin
                        // head_data keeps its value; consumers ignore it while invalid.
                        state     <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_data <= skid_data;
                        head_err  <= skid_err;
                        state     <= OCC_ONE;
                    end
                end
                default: begin
                    state <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [31:0] out_data;

    // Narrow instance for the parameter sweep.
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [7:0]  b_in_imm;
    logic [1:0]  b_in_mode;
    logic [15:0] b_out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected contents of the buffer, head first: {err, data}.
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(16)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
    );

    // Reference extension written as arithmetic on the integer value.
    function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] v;
        v = {16'h0000, imm};
        case (mode)
            2'd0: return {1'b0, v};
            2'd1: return {1'b0, (imm >= 16'h8000) ? v + 32'hFFFF_0000 : v};
`ifdef IMM_EXT_LUI_EN
            2'd2: return {1'b0, v * 32'd65536};
`endif
            default: return {1'b1, v};
        endcase
    endfunction

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                         input logic ordy);
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = ordy;
    endtask

    // Advance the model across the coming rising edge, using only bench-driven inputs.
    task automatic model_step();
        bit do_pop, do_push;
        do_pop  = (exp_q.size() > 0) && out_ready;
        do_push = in_valid && (exp_q.size() < 2);
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(ref_ext(in_imm, in_mode));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 2'd0, 1'b0);
        b_in_valid = 1'b0; b_in_imm = 8'h0; b_in_mode = 2'd0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_modes();
        logic [1:0]  modes [3];
        logic [31:0] want_d[3];
        logic        want_e[3];
        modes = '{2'd1, 2'd0, 2'd2};
`ifdef IMM_EXT_LUI_EN
        want_d = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
        want_e = '{1'b0, 1'b0, 1'b0};
`else
        want_d = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_8001};
        want_e = '{1'b0, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 16'h8001, (i < 3) ? modes[i] : 2'd0, 1'b1);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL modes_in_ready%0d: got %b want 1", i, in_ready); end
            if (i > 0) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL modes_valid%0d: got %b want 1", i, out_valid); end
                n_cmp++; if (out_data !== want_d[i-1]) begin n_fail++; $display("FAIL modes_data%0d: got %h want %h", i, out_data, want_d[i-1]); end
                n_cmp++; if (out_err !== want_e[i-1]) begin n_fail++; $display("FAIL modes_err%0d: got %b want %b", i, out_err, want_e[i-1]); end
            end
            model_step();
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL modes_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] want_d[3];
        logic        vin[4];
        want_d = '{32'd1, 32'd2, 32'd3};
        vin    = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'(k + 1), 2'd0, 1'b0);
            #1;
            n_cmp++; if (in_ready !== (k < 2)) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want %b", k, in_ready, k < 2); end
            model_step();
            @(negedge clk);
        end
        // Extra stall cycle: head must hold.
        drive(1'b1, 16'd3, 2'd0, 1'b0);
        #1;
        n_cmp++; if (out_data !== 32'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall: data %h valid %b want 00000001 1", out_data, out_valid); end
        model_step();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            drive(vin[k], 16'd3, 2'd0, 1'b1);
            #1;
            if (k < 3) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== want_d[k]) begin n_fail++; $display("FAIL bp_order%0d: valid %b data %h want 1 %h", k, out_valid, out_data, want_d[k]); end
            end else begin
                n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup: out_valid %b want 0", out_valid); end
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_reserved();
        drive(1'b1, 16'hFFFF, 2'd3, 1'b1);
        #1; model_step(); @(negedge clk);
        drive(1'b1, 16'h1234, 2'd0, 1'b1);
        #1;
        n_cmp++; if (out_data !== 32'h0000_FFFF || out_err !== 1'b1) begin n_fail++; $display("FAIL rsvd_head: data %h err %b want 0000ffff 1", out_data, out_err); end
        model_step(); @(negedge clk);
        drive(1'b0, 16'h0, 2'd0, 1'b1);
        #1;
        n_cmp++; if (out_data !== 32'h0000_1234 || out_err !== 1'b0) begin n_fail++; $display("FAIL rsvd_next: data %h err %b want 00001234 0", out_data, out_err); end
        model_step(); @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 16'hA000 + 16'(k), 2'd1, 1'b0);
            #1; model_step(); @(negedge clk);
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: in_ready %b want 0", in_ready); end
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: valid %b data %h err %b want 0 00000000 0", out_valid, out_data, out_err); end
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 2'd0, 1'b1);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_param_sweep();
        logic [1:0]  modes [3];
        logic [15:0] want_d[3];
        logic        want_e[3];
        modes = '{2'd1, 2'd2, 2'd0};
`ifdef IMM_EXT_LUI_EN
        want_d = '{16'hFF80, 16'h8000, 16'h0080};
        want_e = '{1'b0, 1'b0, 1'b0};
`else
        want_d = '{16'hFF80, 16'h0080, 16'h0080};
        want_e = '{1'b0, 1'b1, 1'b0};
`endif
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = (i < 3);
            b_in_imm   = 8'h80;
            b_in_mode  = (i < 3) ? modes[i] : 2'd0;
            #1;
            if (i > 0) begin
                n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== want_d[i-1] || b_out_err !== want_e[i-1]) begin
                    n_fail++; $display("FAIL sweep%0d: valid %b data %h err %b want 1 %h %b", i, b_out_valid, b_out_data, b_out_err, want_d[i-1], want_e[i-1]);
                end
            end
            @(negedge clk);
        end
        b_in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0);
            #1;
            n_cmp++; if (in_ready !== (exp_q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_q.size() < 2); end
            n_cmp++; if (out_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                n_cmp++; if ({out_err, out_data} !== exp_q[0]) begin n_fail++; $display("FAIL rnd_head c%0d: got %b/%h want %b/%h", c, out_err, out_data, exp_q[0][32], exp_q[0][31:0]); end
            end
            model_step();
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_param_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, registered immediate extender for the decode/execute boundary of the mini CPU.
- Takes an IN_W-bit immediate plus a mode, and produces an OUT_W-bit operand. Modes are zero-extend, sign-extend and load-upper.
- Results pass through a 2-entry valid/ready skid buffer, so execute-stage stalls back-pressure decode without losing or duplicating immediates.

Parameters:
- IN_W, 16, immediate width; legal range 1..OUT_W.
- OUT_W, 32, extended operand width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has an immediate this cycle.
- in_ready  output  1  block accepts the input this cycle.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  00 zero, 01 sign, 10 load-upper, 11 reserved.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  OUT_W  extended operand.
- out_err  output  1  the entry at the head was issued with a reserved mode.

Behaviour:
- Reset (rst_n low at a rising edge):
  - out_valid=0, out_data=0, out_err=0; both entries are emptied.
  - in_ready is 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all held entries; nothing is replayed.
- Accept condition: in_valid && in_ready at a rising edge. Pop condition: out_valid && out_ready.
- Extension is combinational on the input side; the result is registered.
  - Mode 00: upper OUT_W-IN_W bits are 0.
  - Mode 01: upper bits are copies of in_imm[IN_W-1].
  - Mode 10: in_imm is placed in out_data[OUT_W-1:OUT_W-IN_W]; the low bits are 0. If IN_W==OUT_W this equals mode 00.
  - Mode 11: result as mode 00, with the stored err bit set.
- Occupancy state machine, with states EMPTY, ONE and TWO:
  - EMPTY: in_ready=1, out_valid=0. Accept: load the head register, go to ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept and pop together: head is replaced, stay in ONE.
    - Accept only: new entry goes to the skid register, go to TWO.
    - Pop only: go to EMPTY.
  - TWO: in_ready=0, out_valid=1. Pop: skid moves to head, go to ONE. Any input is ignored because it cannot be accepted.
- Latency: accepted at edge N means visible on out_data after edge N, with out_valid=1 in cycle N+1.
- Throughput: one result per cycle while out_ready stays high.
- in_ready depends only on state, never combinationally on out_ready.
- Ordering: strict FIFO. out_data and out_err stay stable while out_valid=1 and out_ready=0.
- Invalid state encodings recover to EMPTY.
- out_data holds its last value after a pop to EMPTY; consumers ignore it when out_valid=0.

Optional Feature:
- Macro IMM_EXT_LUI_EN.
- Defined: mode 10 performs load-upper as described above.
- Undefined: mode 10 is treated as reserved, giving a zero-extended result with err set. No load-upper shifting logic is synthesised.

Decomposition:
- Shared package cpu_pkg holds the mode constants (IMM_MODE_ZERO=2'b00, IMM_MODE_SIGN=2'b01, IMM_MODE_LUI=2'b10, IMM_MODE_RSVD=2'b11) and the occupancy state encodings.
- One sub-module, imm_ext_core: purely combinational (in_imm, in_mode) -> (data, err), parametrised by IN_W/OUT_W. The top level is the skid-buffer FSM around it.

Test Plan:
- Defaults, out_ready=1: imm=16'h8001 with mode 01, then mode 00, then mode 10 -> out_data 32'hFFFF8001, 32'h00008001, 32'h80010000 on consecutive cycles; out_err=0 throughout.
- Back-pressure: out_ready=0, present 16'h0001, 16'h0002, 16'h0003 with in_valid held -> in_ready falls after two accepts. Then out_ready=1 -> output order 1, 2, 3 with no loss or duplication, and out_data stable while stalled.
- Reserved mode: imm=16'hFFFF, mode 11 -> out_data 32'h0000FFFF, out_err=1; the next entry has out_err=0.
- Reset mid-operation: fill to TWO, pull rst_n low for one edge -> out_valid=0, out_data=0, out_err=0, in_ready=1 the following cycle; no stale entry emerges.
- Parameter sweep (IN_W=8, OUT_W=16): imm=8'h80 mode 01 -> 16'hFF80; mode 10 -> 16'h8000. With IMM_EXT_LUI_EN undefined, mode 10 -> 16'h0080, out_err=1.
- Random valid/ready traffic, 10k cycles: a scoreboard shows FIFO order preserved and in_ready==0 only in state TWO.
